// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller between the EX/MEM pipeline register and a
// word-wide, combinational-read data RAM. Handles MIPS lb/lbu/lh/lhu/lw and
// sb/sh/sw with little-endian lane selection. Loads return formatted and
// extended data one cycle later. Word stores write in the same cycle.
// Byte/half stores become a two-cycle read-modify-write:
//   - cycle 1 (IDLE):   read the word, merge the new lane(s), assert stall.
//   - cycle 2 (RMW_WR): write the merged word back.
// Misaligned or reserved-size requests raise a one-cycle misalign_err pulse.
// They touch nothing else.
//
// Optional feature macro: MEM_ACCESS_STATS_EN
//   defined   : four 16-bit saturating statistics counters
//   undefined : stat_* outputs tied to zero, no counter flops
//
// Parameters
//   DATA_WIDTH  word width; the lane layout assumes 32
//   ADDR_WIDTH  RAM word-address bits (depth 2**ADDR_WIDTH)
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req_valid           request present this cycle
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   stall               combinational; asserted during the RMW read cycle
//   rdata, rdata_valid  registered load result and its one-cycle pulse
//   misalign_err        registered one-cycle error pulse
//   ram_addr            RAM word address
//   ram_wdata, ram_we   RAM write data and write enable
//   ram_q               RAM combinational read data
//   stat_loads, stat_stores, stat_rmw, stat_errs   statistics counters
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  misalign_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [15:0]           stat_loads,
    output logic [15:0]           stat_stores,
    output logic [15:0]           stat_rmw,
    output logic [15:0]           stat_errs
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rdata_valid_q, rdata_valid_d;
    logic                    misalign_q, misalign_d;

    logic [ADDR_WIDTH-1:0]   req_word;
    logic [1:0]              lane;
    logic                    misaligned;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    acc_load;
    logic                    acc_err;
    logic                    acc_word_st;
    logic                    acc_sub_st;

    // Address bits above the RAM word address are intentionally ignored
    // (the address space wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign req_word = req_addr[ADDR_WIDTH+1:2];
    assign lane     = req_addr[1:0];

    // The reserved size is treated as misaligned, whatever the address.
    assign misaligned = (req_size == 2'b11)
                     || (req_size == SIZE_HALF && lane[0])
                     || (req_size == SIZE_WORD && lane != 2'b00);

    // Request classification. Requests are accepted only in IDLE and only
    // while reset is low.
    assign acc_err     = (state_q == IDLE) && req_valid && !reset && misaligned;
    assign acc_load    = (state_q == IDLE) && req_valid && !reset && !misaligned && !req_we;
    assign acc_word_st = (state_q == IDLE) && req_valid && !reset && !misaligned && req_we
                      && (req_size == SIZE_WORD);
    assign acc_sub_st  = (state_q == IDLE) && req_valid && !reset && !misaligned && req_we
                      && (req_size != SIZE_WORD);

    // Load formatting: pick the lane out of the RAM word and extend it.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        byte_sel = ram_q[7:0];
        half_sel = lane[1] ? ram_q[31:16] : ram_q[15:0];
        load_ext = ram_q;
        case (lane)
            2'd0:    byte_sel = ram_q[7:0];
            2'd1:    byte_sel = ram_q[15:8];
            2'd2:    byte_sel = ram_q[23:16];
            default: byte_sel = ram_q[31:24];
        endcase
        if (req_size == SIZE_BYTE) begin
            load_ext = req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (req_size == SIZE_HALF) begin
            load_ext = req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
    end

    // Store merge: the current RAM word with the target lane(s) replaced.
    always_comb begin
        merged = ram_q;
        if (req_size == SIZE_BYTE) begin
            case (lane)
                2'd0:    merged[7:0]   = req_wdata[7:0];
                2'd1:    merged[15:8]  = req_wdata[7:0];
                2'd2:    merged[23:16] = req_wdata[7:0];
                default: merged[31:24] = req_wdata[7:0];
            endcase
        end else if (lane[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0]  = req_wdata[15:0];
        end
    end

    // Next state, RAM interface and stall.
    always_comb begin
        state_d       = state_q;
        merge_d       = merge_q;
        addr_d        = addr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misalign_d    = 1'b0;
        stall         = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = req_word;
        ram_wdata     = req_wdata;

        case (state_q)
            IDLE: begin
                if (acc_err) begin
                    misalign_d = 1'b1;
                end else if (acc_load) begin
                    rdata_d       = load_ext;
                    rdata_valid_d = 1'b1;
                end else if (acc_word_st) begin
                    ram_we = 1'b1;
                end else if (acc_sub_st) begin
                    stall   = 1'b1;
                    merge_d = merged;
                    addr_d  = req_word;
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                // The write-back is suppressed while reset is high, so an
                // RMW caught by reset never reaches the RAM.
                ram_we    = !reset;
                ram_addr  = addr_q;
                ram_wdata = merge_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            merge_q       <= '0;
            addr_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state_q       <= state_d;
            merge_q       <= merge_d;
            addr_q        <= addr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign misalign_err = misalign_q;

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] loads_q, stores_q, rmw_q, errs_q;

    // Each counter saturates at 0xFFFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loads_q  <= '0;
            stores_q <= '0;
            rmw_q    <= '0;
            errs_q   <= '0;
        end else begin
            if (acc_load && loads_q != 16'hFFFF)
                loads_q <= loads_q + 16'd1;
            if ((acc_word_st || acc_sub_st) && stores_q != 16'hFFFF)
                stores_q <= stores_q + 16'd1;
            if (acc_sub_st && rmw_q != 16'hFFFF)
                rmw_q <= rmw_q + 16'd1;
            if (acc_err && errs_q != 16'hFFFF)
                errs_q <= errs_q + 16'd1;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_rmw    = rmw_q;
    assign stat_errs   = errs_q;
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_rmw    = '0;
    assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mem_access_ctrl.
// A behavioural RAM is attached to the RAM port. A reference memory and a
// lane model produce the expected values. Expected load results and error
// pulses are queued when a request is driven. A monitor pops the queue when
// the DUT pulses rdata_valid or misalign_err.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, misalign_err, ram_we;
    logic [31:0] rdata, ram_wdata, ram_q;
    logic [AW-1:0] ram_addr;
    logic [15:0] stat_loads, stat_stores, stat_rmw, stat_errs;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .misalign_err (misalign_err),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_q        (ram_q),
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_rmw     (stat_rmw),
        .stat_errs    (stat_errs)
    );

    // Behavioural RAM driven by the DUT.
    logic [31:0] ram [0:(1<<AW)-1];
    assign ram_q = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    // Reference memory, maintained only from the bench's own stimulus.
    logic [31:0] ref_mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(off)*8 +: 8];
        h = w[int'(off[1])*16 +: 16];
        if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        if (size == 2'b00)      r[int'(off)*8 +: 8]       = wd[7:0];
        else if (size == 2'b01) r[int'(off[1])*16 +: 16]  = wd[15:0];
        else                    r = wd;
        return r;
    endfunction

    // Drive one request and check the combinational RAM-side response.
    // Sub-word stores are held through their RMW_WR cycle.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [AW-1:0] wa;
        bit mis, sub, wst;
        exp_t e;
        wa  = addr[AW+1:2];
        mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        wst = we && !mis && size == 2'b10;
        sub = we && !mis && size != 2'b10;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        check("ram_addr", ram_addr, wa);
        check("stall", stall, sub);
        check("ram_we", ram_we, wst);
        if (wst) begin
            check("ram_wdata_sw", ram_wdata, wdata);
            ref_mem[wa] = wdata;
        end
        if (mis) begin
            e.is_err = 1'b1; e.data = '0; sb_q.push_back(e);
        end else if (!we) begin
            e.is_err = 1'b0; e.data = model_load(ref_mem[wa], size, uns, addr[1:0]); sb_q.push_back(e);
        end
        @(posedge clk);
        if (sub) begin
            @(negedge clk);
            #1;
            check("rmw_stall", stall, 1'b0);
            check("rmw_ram_we", ram_we, 1'b1);
            check("rmw_ram_addr", ram_addr, wa);
            check("rmw_ram_wdata", ram_wdata, model_store(ref_mem[wa], size, addr[1:0], wdata));
            ref_mem[wa] = model_store(ref_mem[wa], size, addr[1:0], wdata);
            @(posedge clk);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
    endtask

    // Scoreboard monitor: output pulses are sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (sb_q.size() != 0 && (rdata_valid || misalign_err)) begin
                e = sb_q.pop_front();
                check("misalign_err", misalign_err, e.is_err);
                check("rdata_valid", rdata_valid, !e.is_err);
                if (!e.is_err) check("rdata", rdata, e.data);
            end else if (sb_q.size() == 0) begin
                check("rdata_valid_unexpected", rdata_valid, 1'b0);
                check("misalign_err_unexpected", misalign_err, 1'b0);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rdata_valid", rdata_valid, 1'b0);
        check("rst_misalign", misalign_err, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        reset = 1'b0;

        // Word store, then word load.
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("word4_after_sw", ram[4], 32'hDEADBEEF);

        // Byte store as RMW, then unsigned byte load.
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'h55);
        access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        check("word4_after_sb", ram[4], 32'hDEAD55EF);

        // Sign/zero extension of the upper lanes.
        access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);

        // Misaligned half, misaligned word, reserved size.
        access(1'b1, 2'b01, 1'b0, 32'h13, 32'h1234);
        access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        access(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
        idle_cycle();
        check("word4_after_misalign", ram[4], 32'hDEAD55EF);

        // Address wrap, half store to the upper lane, byte lane 0, full-rate loads.
        access(1'b0, 2'b10, 1'b0, 32'h0000_0410, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h8081_8283);
        access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234);
        access(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_00A5);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        idle_cycle();
        check("word8_after_rmw", ram[8], 32'h1234_82A5);

        // Reset during the RMW write cycle discards the write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'hAA;
        #1;
        check("rst_rmw_stall_pre", stall, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_rmw_ram_we", ram_we, 1'b0);
        check("rst_rmw_stall", stall, 1'b0);
        check("rst_rmw_rdata", rdata, 32'h0);
        check("rst_rmw_rdata_valid", rdata_valid, 1'b0);
        check("rst_rmw_misalign", misalign_err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_rmw_word4", ram[4], 32'hDEAD55EF);
        req_valid = 1'b0;
        reset = 1'b0;

        // Statistics scenario; also shows the controller is back in IDLE.
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h30, 32'h0102_0304);
        access(1'b1, 2'b00, 1'b0, 32'h31, 32'h77);
        access(1'b1, 2'b00, 1'b0, 32'h33, 32'h88);
        access(1'b1, 2'b10, 1'b0, 32'h31, 32'h0);
        idle_cycle();
        check("word12_after_stats", ram[12], 32'h8802_7704);
`ifdef MEM_ACCESS_STATS_EN
        check("stat_loads", stat_loads, 16'd3);
        check("stat_stores", stat_stores, 16'd3);
        check("stat_rmw", stat_rmw, 16'd2);
        check("stat_errs", stat_errs, 16'd1);
        for (int i = 0; i < 65533; i++) access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        idle_cycle();
        check("stat_loads_sat", stat_loads, 16'hFFFF);
        check("stat_stores_hold", stat_stores, 16'd3);
`else
        check("stat_loads_off", stat_loads, 16'h0);
        check("stat_stores_off", stat_stores, 16'h0);
        check("stat_rmw_off", stat_rmw, 16'h0);
        check("stat_errs_off", stat_errs, 16'h0);
`endif

        repeat (2) idle_cycle();
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
